wb_traffic_gen: RTL



---
 rtl/wb_traffic_gen.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/wb_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module      : wb_traffic_gen
// Description : Pipelined Wishbone test endpoint. The slave port exposes a
//               control/status window plus scratch registers. The master port
//               runs programmable single-outstanding read/write bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_traffic_gen #(
    parameter int DATA_W      = 32,
    parameter int ADR_W       = 28,
    parameter int NUM_SCRATCH = 4,
    parameter int ACK_DELAY   = 0,
    parameter int TIMEOUT     = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wbs_cyc,
    input  logic                  wbs_stb,
    input  logic                  wbs_we,
    input  logic [ADR_W-1:0]      wbs_adr,
    input  logic [DATA_W-1:0]     wbs_dat_m,
    input  logic [DATA_W/8-1:0]   wbs_sel,
    output logic                  wbs_ack,
    output logic                  wbs_stall,
    output logic                  wbs_err,
    output logic [DATA_W-1:0]     wbs_dat_s,
    output logic                  wbm_cyc,
    output logic                  wbm_stb,
    output logic                  wbm_we,
    output logic [ADR_W-1:0]      wbm_adr,
    output logic [DATA_W-1:0]     wbm_dat_m,
    output logic [DATA_W/8-1:0]   wbm_sel,
    input  logic                  wbm_ack,
    input  logic                  wbm_err,
    input  logic                  wbm_stall,
    input  logic [DATA_W-1:0]     wbm_dat_s
);
    localparam int         c_sel_w    = DATA_W / 8;
    localparam logic [4:0] c_ctrl     = 5'd0;
    localparam logic [4:0] c_status   = 5'd1;
    localparam logic [4:0] c_addr     = 5'd2;
    localparam logic [4:0] c_len      = 5'd3;
    localparam logic [4:0] c_wdata    = 5'd4;
    localparam logic [4:0] c_rsum     = 5'd5;
    localparam int         c_scr_base = 6;
    localparam logic [3:0] c_dly      = 4'(ACK_DELAY);
    localparam logic [31:0] c_tmo_last = 32'(TIMEOUT - 1);

    typedef enum logic [1:0] {c_idle = 2'd0, c_req = 2'd1, c_wait = 2'd2, c_fin = 2'd3} state_t;

    state_t                r_state, w_next;
    logic                  r_pend, r_busy, r_done, r_err, r_we_cfg, r_incr, r_mwe, r_minc;
    logic [3:0]            r_cnt;
    logic [DATA_W-1:0]     r_rdat, r_wdata, r_rsum, r_mdat, w_rdata;
    logic [ADR_W-1:0]      r_addr, r_madr;
    logic [15:0]           r_len, r_rem;
    logic [31:0]           r_tmo;
    logic [DATA_W-1:0]     r_scr [NUM_SCRATCH];
    logic                  w_acc, w_wr, w_sack, w_start, w_active, w_tmo, w_abort, w_ack_ok, w_len_zero;
    logic [4:0]            w_off;
    logic                  w_unused;

    // Byte-lane merge of a register write
    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_v,
                                                input logic [DATA_W-1:0] new_v,
                                                input logic [c_sel_w-1:0] sel);
        logic [DATA_W-1:0] res;
        res = old_v;
        for (int b = 0; b < c_sel_w; b++)
            if (sel[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
        return res;
    endfunction

    assign w_off      = wbs_adr[4:0];
    assign w_unused   = ^wbs_adr[ADR_W-1:5];
    assign w_sack     = r_pend && (r_cnt == 4'd0);
    assign wbs_stall  = r_pend && (r_cnt != 4'd0);
    assign wbs_ack    = w_sack && wbs_cyc;
    assign wbs_err    = 1'b0;
    assign wbs_dat_s  = wbs_ack ? r_rdat : '0;
    assign w_acc      = wbs_cyc && wbs_stb && !wbs_stall;
    assign w_wr       = w_acc && wbs_we;
    assign w_len_zero = (r_len == 16'd0);
    assign w_start    = w_wr && (w_off == c_ctrl) && !r_busy && wbs_sel[0] && wbs_dat_m[0];
    assign w_active   = (r_state == c_req) || (r_state == c_wait);
    assign w_tmo      = (TIMEOUT != 0) && w_active && (r_tmo == c_tmo_last);
    assign w_abort    = w_active && (wbm_err || w_tmo);
    assign w_ack_ok   = (r_state == c_wait) && wbm_ack && !w_abort;
    assign wbm_adr    = r_madr;
    assign wbm_dat_m  = r_mdat;

    // Register read mux; unmapped offsets return zero
    always_comb begin
        w_rdata = '0;
        case (w_off)
            c_ctrl:   w_rdata = DATA_W'({r_incr, r_we_cfg, 1'b0});
            c_status: w_rdata = DATA_W'({r_err, r_done, r_busy});
            c_addr:   w_rdata = DATA_W'(r_addr);
            c_len:    w_rdata = DATA_W'(r_len);
            c_wdata:  w_rdata = r_wdata;
            c_rsum:   w_rdata = r_rsum;
            default:  w_rdata = '0;
        endcase
        for (int i = 0; i < NUM_SCRATCH; i++)
            if (w_off == 5'(c_scr_base + i)) w_rdata = r_scr[i];
    end

    // Slave handshake: latch read data at acceptance, count down the ack delay
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= 1'b0;
            r_cnt  <= 4'd0;
            r_rdat <= '0;
        end else if (w_acc) begin
            r_pend <= 1'b1;
            r_cnt  <= c_dly;
            r_rdat <= w_rdata;
        end else if (!wbs_cyc || w_sack) begin
            r_pend <= 1'b0;
        end else if (wbs_stall) begin
            r_cnt  <= r_cnt - 4'd1;
        end
    end

    // Configuration and scratch registers; burst config is frozen while busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we_cfg <= 1'b0;
            r_incr   <= 1'b0;
            r_addr   <= '0;
            r_len    <= '0;
            r_wdata  <= '0;
            for (int i = 0; i < NUM_SCRATCH; i++) r_scr[i] <= '0;
        end else if (w_wr) begin
            if (!r_busy) begin
                case (w_off)
                    c_ctrl:  if (wbs_sel[0]) begin
                                 r_we_cfg <= wbs_dat_m[1];
                                 r_incr   <= wbs_dat_m[2];
                             end
                    c_addr:  r_addr  <= ADR_W'(merge(DATA_W'(r_addr), wbs_dat_m, wbs_sel));
                    c_len:   r_len   <= 16'(merge(DATA_W'(r_len), wbs_dat_m, wbs_sel));
                    c_wdata: r_wdata <= merge(r_wdata, wbs_dat_m, wbs_sel);
                    default: ;
                endcase
            end
            for (int i = 0; i < NUM_SCRATCH; i++)
                if (w_off == 5'(c_scr_base + i)) r_scr[i] <= merge(r_scr[i], wbs_dat_m, wbs_sel);
        end
    end

    // Master datapath and status flags; hardware set wins over write-1-clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_mwe  <= 1'b0;
            r_minc <= 1'b0;
            r_madr <= '0;
            r_mdat <= '0;
            r_rem  <= '0;
            r_rsum <= '0;
            r_tmo  <= '0;
        end else begin
            if (w_wr && (w_off == c_status) && wbs_sel[0]) begin
                if (wbs_dat_m[1]) r_done <= 1'b0;
                if (wbs_dat_m[2]) r_err  <= 1'b0;
            end
            if (w_start) begin
                r_madr <= r_addr;
                r_mdat <= r_wdata;
                r_rem  <= r_len;
                r_mwe  <= wbs_dat_m[1];
                r_minc <= wbs_dat_m[2];
                r_rsum <= '0;
                r_tmo  <= '0;
                r_busy <= !w_len_zero;
                if (w_len_zero) r_done <= 1'b1;
            end else if (w_abort) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
                r_err  <= 1'b1;
            end else if (w_ack_ok) begin
                r_madr <= r_madr + ADR_W'(r_minc);
                r_mdat <= r_mdat + DATA_W'(1);
                r_rem  <= r_rem - 16'd1;
                r_tmo  <= '0;
                if (!r_mwe) r_rsum <= r_rsum + wbm_dat_s;
                if (r_rem == 16'd1) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end else if (w_active) begin
                r_tmo <= r_tmo + 32'd1;
            end
        end
    end

    // Master FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_idle;
        else     r_state <= w_next;
    end

    // Master FSM next state and bus strobes
    always_comb begin
        w_next  = r_state;
        wbm_cyc = 1'b0;
        wbm_stb = 1'b0;
        wbm_we  = 1'b0;
        wbm_sel = '0;
        case (r_state)
            c_idle, c_fin: begin
                if (w_start && !w_len_zero) w_next = c_req;
                else                        w_next = c_idle;
            end
            c_req: begin
                wbm_cyc = 1'b1;
                wbm_stb = 1'b1;
                wbm_we  = r_mwe;
                wbm_sel = '1;
                if (w_abort)         w_next = c_fin;
                else if (!wbm_stall) w_next = c_wait;
            end
            c_wait: begin
                wbm_cyc = 1'b1;
                wbm_we  = r_mwe;
                if (w_abort)      w_next = c_fin;
                else if (wbm_ack) w_next = (r_rem == 16'd1) ? c_fin : c_req;
            end
            default: w_next = c_idle;
        endcase
    end
endmodule
`default_nettype wire
